fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
// fifo_stream_reader: read-side adapter for sync_fifo.
// Hides the one-cycle FIFO read latency behind a valid/ready output stream.
// A 2-entry output buffer plus an in-flight read flag keeps one word per
// cycle flowing while m_ready_i stays high, and never over-reads under
// backpressure. Word order is preserved.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_n           asynchronous active-low reset
//   fifo_rd_en_o    read strobe to sync_fifo
//   fifo_rd_data_i  sync_fifo read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i    sync_fifo empty flag
//   m_valid_o       output word valid
//   m_data_o        output word
//   m_ready_i       downstream accept
//   flush_i         synchronous discard of buffered and in-flight words
//
// Optional (macro FIFO_RD_STATS_EN):
//   beat_count_o    pops, wraps at 2^32
//   stall_count_o   cycles with m_valid_o=1 and m_ready_i=0, saturating
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_rd_data_i,
    input  logic             fifo_empty_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    input  logic             flush_i
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      beat_count_o,
    output logic [31:0]      stall_count_o
`endif
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("fifo_stream_reader: BUF_DEPTH must be 2");
    end

    logic [WIDTH-1:0] buf_q [2];
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;

    logic       pop;
    logic       capture;
    logic [1:0] level;

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = buf_q[head_q];
    assign pop       = m_valid_o & m_ready_i;
    // Data of a read issued last cycle lands now, unless a flush drops it.
    assign capture   = inflight_q & ~flush_i;

    // occ + inflight never exceeds 2, and pop implies occ >= 1, so 2 bits suffice.
    assign level = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        fifo_rd_en_o = 1'b0;
        occ_d        = occ_q;
        inflight_d   = 1'b0;
        head_d       = head_q;
        tail_d       = tail_q;
        if (flush_i) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            fifo_rd_en_o = ~fifo_empty_i & (level < 2'd2);
            inflight_d   = fifo_rd_en_o;
            occ_d        = occ_q + {1'b0, capture} - {1'b0, pop};
            head_d       = head_q ^ pop;
            tail_d       = tail_q ^ capture;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (capture) begin
                buf_q[tail_q] <= fifo_rd_data_i;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] beat_q, stall_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (pop) begin
                beat_q <= beat_q + 32'd1;
            end
            if (m_valid_o && !m_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign beat_count_o  = beat_q;
    assign stall_count_o = stall_q;
`endif

endmodule
